// File: rtl/alu_seq.sv
// Digit-carry ALU with single-cycle add/logic/shift ops and an optional
// iterative unsigned multiply / restoring divide engine sharing the result registers.
module alu_seq #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MULDIV_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rdy,
    input  logic [3:0]       op,
    input  logic             right,
    input  logic [WIDTH-1:0] ai,
    input  logic [WIDTH-1:0] bi,
    input  logic             ci,
    input  logic             bcd,
    input  logic             start,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             co,
    output logic             v,
    output logic             z,
    output logic             n,
    output logic             hc,
    output logic             busy,
    output logic             done
);
    localparam int unsigned NDig = WIDTH / 4;
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;
    state_e state_q, state_d;

    logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
    logic             co_q, co_d, v_q, v_d, z_q, z_d, n_q, n_d, hc_q, hc_d;
    logic             done_q, done_d, is_div_q, is_div_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;

    logic             pass_a, mdiv_go, last_iter;
    logic [WIDTH-1:0] logic_res, b_opnd, add_sum;
    logic             add_cin, carry, dig0_c;
    logic [4:0]       dsum;
    logic [WIDTH-1:0] it_hi, it_lo, diff;
    logic [WIDTH:0]   msum, r_sh;
    logic             ge;

    // 100x outside an engine launch degrades to pass-A
    assign pass_a    = (op[3:1] == 3'b100);
    assign mdiv_go   = (MULDIV_EN != 0) && start && pass_a;
    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        unique case (op[1:0])
            2'b00:   logic_res = ai | bi;
            2'b01:   logic_res = ai & bi;
            2'b10:   logic_res = ai ^ bi;
            default: logic_res = ai;
        endcase
        if (pass_a) logic_res = ai;
        if (right)  logic_res = {ci, ai[WIDTH-1:1]};
        unique case (op[3:2])
            2'b00:   b_opnd = bi;
            2'b01:   b_opnd = ~bi;
            2'b10:   b_opnd = logic_res;
            default: b_opnd = '0;
        endcase
        if (pass_a) b_opnd = '0;
        add_cin = ci & ~right & (op[3:2] != 2'b11) & ~pass_a;
    end

    // Digit-serial carry chain; bcd promotes a digit sum of 10..15 to a carry
    always_comb begin
        carry   = add_cin;
        dig0_c  = 1'b0;
        dsum    = '0;
        add_sum = '0;
        for (int i = 0; i < int'(NDig); i++) begin
            dsum = {1'b0, logic_res[4*i +: 4]} + {1'b0, b_opnd[4*i +: 4]} + {4'b0, carry};
            add_sum[4*i +: 4] = dsum[3:0];
            carry = dsum[4] | (bcd & (dsum >= 5'd10));
            if (i == 0) dig0_c = carry;
        end
    end

    always_comb begin
        msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        r_sh  = {hi_q, lo_q[WIDTH-1]};
        ge    = (r_sh >= {1'b0, opnd_q});
        diff  = r_sh[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            it_hi = ge ? diff : r_sh[WIDTH-1:0];
            it_lo = {lo_q[WIDTH-2:0], ge};
        end else begin
            it_hi = msum[WIDTH:1];
            it_lo = {msum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            unique case (state_q)
                StIdle:  if (mdiv_go) state_d = StBusy;
                default: if (last_iter) state_d = StIdle;
            endcase
        end
    end

    always_comb busy = (state_q == StBusy);

    always_comb begin
        out_d = out_q;  out_hi_d = out_hi_q;
        co_d = co_q;  v_d = v_q;  z_d = z_q;  n_d = n_q;  hc_d = hc_q;
        done_d = done_q;  is_div_d = is_div_q;  cnt_d = cnt_q;
        hi_d = hi_q;  lo_d = lo_q;  opnd_d = opnd_q;
        if (rdy) begin
            done_d = 1'b0;
            if (state_q == StIdle) begin
                if (mdiv_go) begin
                    is_div_d = op[0];
                    cnt_d    = '0;
                    hi_d     = '0;
                    lo_d     = op[0] ? ai : bi;
                    opnd_d   = op[0] ? bi : ai;
                end else begin
                    out_d    = add_sum;
                    out_hi_d = '0;
                    co_d     = right ? ai[0] : carry;
                    hc_d     = dig0_c;
                    n_d      = add_sum[WIDTH-1];
                    z_d      = (add_sum == '0);
                    v_d      = ai[WIDTH-1] ^ b_opnd[WIDTH-1] ^ co_d ^ n_d;
                end
            end else begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + CntW'(1);
                if (last_iter) begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    out_d    = it_lo;
                    out_hi_d = it_hi;
                    co_d     = 1'b0;
                    hc_d     = 1'b0;
                    if (is_div_q) begin
                        z_d = (it_lo == '0);
                        n_d = it_lo[WIDTH-1];
                        v_d = (opnd_q == '0);
                    end else begin
                        z_d = (it_lo == '0) && (it_hi == '0);
                        n_d = it_hi[WIDTH-1];
                        v_d = (it_hi != '0);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;  out_hi_q <= '0;
            co_q <= 1'b0;  v_q <= 1'b0;  z_q <= 1'b1;  n_q <= 1'b0;  hc_q <= 1'b0;
            done_q <= 1'b0;  is_div_q <= 1'b0;  cnt_q <= '0;
            hi_q <= '0;  lo_q <= '0;  opnd_q <= '0;
        end else begin
            out_q <= out_d;  out_hi_q <= out_hi_d;
            co_q <= co_d;  v_q <= v_d;  z_q <= z_d;  n_q <= n_d;  hc_q <= hc_d;
            done_q <= done_d;  is_div_q <= is_div_d;  cnt_q <= cnt_d;
            hi_q <= hi_d;  lo_q <= lo_d;  opnd_q <= opnd_d;
        end
    end

    assign out    = out_q;
    assign out_hi = out_hi_q;
    assign co     = co_q;
    assign v      = v_q;
    assign z      = z_q;
    assign n      = n_q;
    assign hc     = hc_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an 8-bit instance for the datapath and engine,
// a 16-bit instance for abort-on-reset.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       reset, rdy, right, ci, bcd, start;
    logic [3:0] op;
    logic [7:0] ai, bi, out, out_hi;
    logic       co, v, z, n, hc, busy, done;

    logic        r16, st16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, out16, out_hi16;
    logic        co16, v16, z16, n16, hc16, busy16, done16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .MULDIV_EN(1)) dut8 (
        .clk(clk), .reset(reset), .rdy(rdy), .op(op), .right(right), .ai(ai), .bi(bi),
        .ci(ci), .bcd(bcd), .start(start), .out(out), .out_hi(out_hi), .co(co), .v(v),
        .z(z), .n(n), .hc(hc), .busy(busy), .done(done)
    );

    alu_seq #(.WIDTH(16), .MULDIV_EN(1)) dut16 (
        .clk(clk), .reset(r16), .rdy(rdy), .op(op16), .right(1'b0), .ai(a16), .bi(b16),
        .ci(1'b0), .bcd(1'b0), .start(st16), .out(out16), .out_hi(out_hi16), .co(co16),
        .v(v16), .z(z16), .n(n16), .hc(hc16), .busy(busy16), .done(done16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch MUL/DIV on dut8 and count edges (acceptance included) until done
    task automatic run_md(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                          input int stall_at, input int stall_len, output int edges);
        op = o; ai = a; bi = b; start = 1'b1; rdy = 1'b1;
        tick();
        edges = 1;
        start = 1'b0; op = 4'h3; ai = 8'h5A; bi = 8'hA5;
        while (!done && edges < 40) begin
            rdy = (edges >= stall_at && edges < stall_at + stall_len) ? 1'b0 : 1'b1;
            tick();
            edges++;
        end
        rdy = 1'b1;
    endtask

    task automatic single(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic d, input logic r);
        op = o; ai = a; bi = b; ci = c; bcd = d; right = r; start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; r16 = 1'b1; rdy = 1'b0;
        tick();
        n_vec++;
        if ({out, out_hi} !== 16'h0000) begin
            n_err++; $display("FAIL reset_out got %h/%h want 00/00", out, out_hi);
        end
        n_vec++;
        if ({co, v, z, n, hc, busy, done} !== 7'b0010000) begin
            n_err++; $display("FAIL reset_flags got %b want 0010000", {co, v, z, n, hc, busy, done});
        end
        reset = 1'b0; r16 = 1'b0; rdy = 1'b1;
    endtask

    task automatic test_add();
        single(4'h3, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({out, co, v, z, n, hc} !== {8'hA0, 5'b01010}) begin
            n_err++; $display("FAIL add_ovf got %h %b want a0 01010", out, {co, v, z, n, hc});
        end
        single(4'h3, 8'h45, 8'h55, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({out, co, v, z, n, hc} !== {8'hAA, 5'b10011}) begin
            n_err++; $display("FAIL add_bcd got %h %b want aa 10011", out, {co, v, z, n, hc});
        end
        single(4'h7, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if ({out, co, v, z, n, hc} !== {8'h0F, 5'b10000}) begin
            n_err++; $display("FAIL sub got %h %b want 0f 10000", out, {co, v, z, n, hc});
        end
        single(4'hB, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if ({out, co, v, z, n, hc} !== {8'h03, 5'b11000}) begin
            n_err++; $display("FAIL dbl got %h %b want 03 11000", out, {co, v, z, n, hc});
        end
    endtask

    task automatic test_logic();
        single(4'hC, 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if ({out, co, v, z, n, hc} !== {8'hFF, 5'b00010}) begin
            n_err++; $display("FAIL or got %h %b want ff 00010", out, {co, v, z, n, hc});
        end
        single(4'hD, 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if ({out, co, v, z, n, hc} !== {8'h00, 5'b01100}) begin
            n_err++; $display("FAIL and got %h %b want 00 01100", out, {co, v, z, n, hc});
        end
        single(4'hE, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({out, co, v, z, n, hc} !== {8'h33, 5'b00000}) begin
            n_err++; $display("FAIL xor got %h %b want 33 00000", out, {co, v, z, n, hc});
        end
        single(4'hF, 8'h81, 8'h00, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if ({out, co, v, z, n, hc} !== {8'hC0, 5'b11010}) begin
            n_err++; $display("FAIL ror got %h %b want c0 11010", out, {co, v, z, n, hc});
        end
        right = 1'b0;
        rdy = 1'b0;
        single(4'h3, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (out !== 8'hC0) begin
            n_err++; $display("FAIL rdy_freeze got %h want c0", out);
        end
        rdy = 1'b1;
        single(4'h3, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        start = 1'b1; op = 4'h3; ai = 8'h01; bi = 8'h02;
        tick();
        start = 1'b0;
        n_vec++;
        if ({out, busy} !== {8'h03, 1'b0}) begin
            n_err++; $display("FAIL start_add got %h busy %b want 03 busy 0", out, busy);
        end
    endtask

    task automatic test_mul();
        int cyc;
        single(4'h3, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        op = 4'h8; ai = 8'hFF; bi = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0; op = 4'h9; ai = 8'h00; bi = 8'h00;
        cyc = 0;
        while (busy && cyc < 20) begin
            if (cyc == 3) begin
                n_vec++;
                if ({out, out_hi, done} !== {8'h46, 8'h00, 1'b0}) begin
                    n_err++; $display("FAIL mul_hold got %h/%h done %b want 46/00 0", out, out_hi, done);
                end
                start = 1'b1;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        n_vec++;
        if (cyc !== 8) begin
            n_err++; $display("FAIL mul_busy_len got %0d want 8", cyc);
        end
        n_vec++;
        if ({done, out, out_hi, co, v, z, n, hc} !== {1'b1, 8'h01, 8'hFE, 5'b01010}) begin
            n_err++; $display("FAIL mul_ff got %b %h %h %b want 1 01 fe 01010",
                              done, out, out_hi, {co, v, z, n, hc});
        end
        op = 4'h3;
        tick();
        n_vec++;
        if ({done, busy} !== 2'b00) begin
            n_err++; $display("FAIL mul_done_clr got %b want 00", {done, busy});
        end
        run_md(4'h8, 8'h00, 8'h05, 100, 0, cyc);
        n_vec++;
        if ({out, out_hi, co, v, z, n, hc} !== {8'h00, 8'h00, 5'b00100}) begin
            n_err++; $display("FAIL mul_zero got %h %h %b want 00 00 00100", out, out_hi, {co, v, z, n, hc});
        end
    endtask

    task automatic test_div();
        int e;
        run_md(4'h9, 8'd200, 8'd7, 100, 0, e);
        n_vec++;
        if ({e, done, out, out_hi, co, v, z, n, hc} !== {32'd9, 1'b1, 8'h1C, 8'h04, 5'b00000}) begin
            n_err++; $display("FAIL div got edges %0d %b %h %h %b want 9 1 1c 04 00000",
                              e, done, out, out_hi, {co, v, z, n, hc});
        end
        rdy = 1'b0;
        tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++; $display("FAIL done_hold_rdy0 got %b want 1", done);
        end
        rdy = 1'b1;
        run_md(4'h9, 8'd200, 8'd7, 3, 3, e);
        n_vec++;
        if ({e, done, out, out_hi, v} !== {32'd12, 1'b1, 8'h1C, 8'h04, 1'b0}) begin
            n_err++; $display("FAIL div_stall got edges %0d %b %h %h v%b want 12 1 1c 04 v0",
                              e, done, out, out_hi, v);
        end
        run_md(4'h9, 8'h37, 8'h00, 100, 0, e);
        n_vec++;
        if ({e, out, out_hi, co, v, z, n, hc} !== {32'd9, 8'hFF, 8'h37, 5'b01010}) begin
            n_err++; $display("FAIL div0 got edges %0d %h %h %b want 9 ff 37 01010",
                              e, out, out_hi, {co, v, z, n, hc});
        end
    endtask

    task automatic test_back_to_back();
        int e;
        run_md(4'h8, 8'h10, 8'h10, 100, 0, e);
        single(4'h3, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({out, out_hi, done, busy, z} !== {8'h02, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL b2b got %h %h %b want 02 00 000", out, out_hi, {done, busy, z});
        end
    endtask

    task automatic test_abort16();
        int e;
        op16 = 4'h8; a16 = 16'h1234; b16 = 16'h5678; st16 = 1'b1;
        tick();
        st16 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if (busy16 !== 1'b1) begin
            n_err++; $display("FAIL abort_prebusy got %b want 1", busy16);
        end
        r16 = 1'b1;
        tick();
        r16 = 1'b0;
        n_vec++;
        if ({busy16, done16, out16, z16} !== {2'b00, 16'h0000, 1'b1}) begin
            n_err++; $display("FAIL abort got busy %b done %b out %h z %b want 0 0 0000 1",
                              busy16, done16, out16, z16);
        end
        op16 = 4'h8; a16 = 16'd3; b16 = 16'd5; st16 = 1'b1;
        tick();
        st16 = 1'b0;
        e = 1;
        n_vec++;
        if (busy16 !== 1'b1) begin
            n_err++; $display("FAIL restart_busy got %b want 1", busy16);
        end
        while (!done16 && e < 60) begin
            tick();
            e++;
        end
        n_vec++;
        if ({e, out16, out_hi16, v16} !== {32'd17, 16'd15, 16'd0, 1'b0}) begin
            n_err++; $display("FAIL restart_mul got edges %0d %h %h v%b want 17 000f 0000 v0",
                              e, out16, out_hi16, v16);
        end
    endtask

    initial begin
        reset = 1'b1; rdy = 1'b1; right = 1'b0; ci = 1'b0; bcd = 1'b0; start = 1'b0;
        op = 4'h0; ai = 8'h00; bi = 8'h00;
        r16 = 1'b1; st16 = 1'b0; op16 = 4'h0; a16 = 16'h0; b16 = 16'h0;
        test_reset();
        test_add();
        test_logic();
        test_mul();
        test_div();
        test_back_to_back();
        test_abort16();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
